pipeline_packer: RTL and testbench

- Width up-converter placed directly upstream of a pipeline stage in the datapath.
- Accepts narrow C_IN_WIDTH words on a valid/ready interface and packs C_RATIO of them into one wide word. Lane 0 is the first-arrived word and occupies the LSBs.
- A word flagged as packet end flushes a partially filled wide word early.
- Emits the wide word, its lane count and its end flag on a valid/ready interface that drives the pipeline's write port directly.

---
 rtl/pipeline_packer.sv | 83 ++++++++
 tb/tb_pipeline_packer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_packer.sv
// Packs C_RATIO narrow words into one wide word (lane 0 = LSBs); END flushes a partial word early.
// One cycle from completing input to registered output; input stalls only while a held output is not accepted.
module pipeline_packer #(
  parameter int C_IN_WIDTH    = 32,
  parameter int C_RATIO       = 4,
  parameter int C_OUT_WIDTH   = C_IN_WIDTH * C_RATIO,
  parameter int C_COUNT_WIDTH = $clog2(C_RATIO + 1)
) (
  input  logic                     CLK,
  input  logic                     RST_IN,
  input  logic [C_IN_WIDTH-1:0]    WR_DATA,
  input  logic                     WR_DATA_VALID,
  input  logic                     WR_DATA_END,
  output logic                     WR_DATA_READY,
  output logic [C_OUT_WIDTH-1:0]   RD_DATA,
  output logic [C_COUNT_WIDTH-1:0] RD_DATA_WORDS,
  output logic                     RD_DATA_END,
  output logic                     RD_DATA_VALID,
  input  logic                     RD_DATA_READY
);

  localparam logic [C_COUNT_WIDTH-1:0] LAST_LANE = C_COUNT_WIDTH'(C_RATIO - 1);

  logic [C_OUT_WIDTH-1:0]   acc;
  logic [C_OUT_WIDTH-1:0]   merged;
  logic [C_OUT_WIDTH-1:0]   out_data;
  logic [C_COUNT_WIDTH-1:0] count;
  logic [C_COUNT_WIDTH-1:0] out_words;
  logic                     out_end;
  logic                     out_valid;
  logic                     ready;
  logic                     take;
  logic                     done;

  assign ready = ~out_valid | RD_DATA_READY;
  assign take  = WR_DATA_VALID & ready;
  assign done  = (count == LAST_LANE) | WR_DATA_END;

  // Lanes above count are always zero in acc, so the merged word has clean unused lanes.
  always_comb begin
    merged = acc;
    for (int i = 0; i < C_RATIO; i++) begin
      if (count == C_COUNT_WIDTH'(i)) begin
        merged[i*C_IN_WIDTH +: C_IN_WIDTH] = WR_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_words <= '0;
      out_end   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && RD_DATA_READY) begin
        out_valid <= 1'b0;
      end
      if (take) begin
        if (done) begin
          out_data  <= merged;
          out_words <= count + 1'b1;
          out_end   <= WR_DATA_END;
          out_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= merged;
          count <= count + 1'b1;
        end
      end
    end
  end

  assign WR_DATA_READY = ready;
  assign RD_DATA       = out_data;
  assign RD_DATA_WORDS = out_words;
  assign RD_DATA_END   = out_end;
  assign RD_DATA_VALID = out_valid;

endmodule

// File: tb/tb_pipeline_packer.sv
// Bench for pipeline_packer (8-bit words, ratio 4): a scoreboard queue filled as words are accepted,
// drained by an output monitor, plus per-scenario inline checks of timing, ready and reset behaviour.
module tb_pipeline_packer;

  localparam int W = 8;
  localparam int R = 4;

  typedef struct packed {
    logic [W*R-1:0] data;
    logic [2:0]     words;
    logic           last;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST_IN;
  logic [W-1:0]   WR_DATA;
  logic           WR_DATA_VALID;
  logic           WR_DATA_END;
  logic           WR_DATA_READY;
  logic [W*R-1:0] RD_DATA;
  logic [2:0]     RD_DATA_WORDS;
  logic           RD_DATA_END;
  logic           RD_DATA_VALID;
  logic           RD_DATA_READY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;

  exp_t exp_q[$];
  int   out_cyc[$];

  logic [W*R-1:0] m_acc = '0;
  int             m_cnt = 0;

  pipeline_packer #(.C_IN_WIDTH(W), .C_RATIO(R)) dut (
    .CLK           (CLK),
    .RST_IN        (RST_IN),
    .WR_DATA       (WR_DATA),
    .WR_DATA_VALID (WR_DATA_VALID),
    .WR_DATA_END   (WR_DATA_END),
    .WR_DATA_READY (WR_DATA_READY),
    .RD_DATA       (RD_DATA),
    .RD_DATA_WORDS (RD_DATA_WORDS),
    .RD_DATA_END   (RD_DATA_END),
    .RD_DATA_VALID (RD_DATA_VALID),
    .RD_DATA_READY (RD_DATA_READY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // Output side: pop on every transfer and check that held words do not change.
  exp_t e;
  exp_t held;
  bit   prev_hold = 1'b0;
  always @(negedge CLK) begin
    if (RST_IN) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        total++;
        if (RD_DATA_VALID !== 1'b1 || {RD_DATA, RD_DATA_WORDS, RD_DATA_END} !== held) begin
          bad++;
          $display("FAIL hold_stable got valid=%b data=%h words=%0d end=%b exp data=%h words=%0d end=%b",
                   RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END, held.data, held.words, held.last);
        end
      end
      prev_hold = RD_DATA_VALID && !RD_DATA_READY;
      held = {RD_DATA, RD_DATA_WORDS, RD_DATA_END};
      if (RD_DATA_VALID && RD_DATA_READY) begin
        out_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got data=%h words=%0d end=%b exp none", RD_DATA, RD_DATA_WORDS, RD_DATA_END);
        end else begin
          e = exp_q.pop_front();
          if ({RD_DATA, RD_DATA_WORDS, RD_DATA_END} !== e) begin
            bad++;
            $display("FAIL out_word got data=%h words=%0d end=%b exp data=%h words=%0d end=%b",
                     RD_DATA, RD_DATA_WORDS, RD_DATA_END, e.data, e.words, e.last);
          end
        end
      end
    end
  end

  // Offers one word until accepted (called and returning at posedge+1), updating the reference packer.
  task automatic send(input logic [W-1:0] d, input logic last);
    logic took;
    int   n;
    n = 0;
    took = 1'b0;
    WR_DATA = d;
    WR_DATA_END = last;
    WR_DATA_VALID = 1'b1;
    forever begin
      if (rand_rdy) RD_DATA_READY = 1'($urandom_range(0, 1));
      #1;
      took = WR_DATA_READY;
      @(posedge CLK); #1;
      if (took) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout got accepted=0 exp accepted=1 data=%h", d);
        break;
      end
    end
    if (took) begin
      m_acc[m_cnt*W +: W] = d;
      if (m_cnt == R - 1 || last) begin
        exp_q.push_back({m_acc, 3'(m_cnt + 1), last});
        m_acc = '0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drain();
    WR_DATA_VALID = 1'b0;
    WR_DATA_END = 1'b0;
    RD_DATA_READY = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b data=%h words=%0d end=%b exp all zero",
               RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END);
    end
    total++;
    if (WR_DATA_READY !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b exp 1", WR_DATA_READY);
    end
    RST_IN = 1'b0;
  endtask

  task automatic test_stream();
    logic [W-1:0] words_in [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    RD_DATA_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (WR_DATA_READY !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready got %b exp 1 at word %0d", WR_DATA_READY, i);
      end
      send(words_in[i], 1'b0);
    end
    total++;
    if (RD_DATA_VALID !== 1'b1 || RD_DATA !== 32'h44332211 || RD_DATA_WORDS !== 3'd4 || RD_DATA_END !== 1'b0) begin
      bad++;
      $display("FAIL stream_word got valid=%b data=%h words=%0d end=%b exp valid=1 data=44332211 words=4 end=0",
               RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END);
    end
    WR_DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (RD_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL stream_valid_one_cycle got %b exp 0", RD_DATA_VALID);
    end
    drain();
  endtask

  task automatic test_flush();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    total++;
    if (RD_DATA_VALID !== 1'b1 || RD_DATA !== 32'h0000A2A1 || RD_DATA_WORDS !== 3'd2 || RD_DATA_END !== 1'b1) begin
      bad++;
      $display("FAIL flush_word got valid=%b data=%h words=%0d end=%b exp valid=1 data=0000a2a1 words=2 end=1",
               RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END);
    end
    send(8'h5C, 1'b1);
    total++;
    if (RD_DATA_VALID !== 1'b1 || RD_DATA !== 32'h0000005C || RD_DATA_WORDS !== 3'd1 || RD_DATA_END !== 1'b1) begin
      bad++;
      $display("FAIL single_word got valid=%b data=%h words=%0d end=%b exp valid=1 data=0000005c words=1 end=1",
               RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END);
    end
    drain();
  endtask

  task automatic test_backpressure();
    RD_DATA_READY = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    RD_DATA_READY = 1'b0;
    WR_DATA = 8'h05;
    WR_DATA_END = 1'b0;
    WR_DATA_VALID = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (WR_DATA_READY !== 1'b0 || RD_DATA_VALID !== 1'b1 || RD_DATA !== 32'h04030201 || RD_DATA_WORDS !== 3'd4) begin
        bad++;
        $display("FAIL stall_cycle%0d got wr_ready=%b valid=%b data=%h words=%0d exp wr_ready=0 valid=1 data=04030201 words=4",
                 i, WR_DATA_READY, RD_DATA_VALID, RD_DATA, RD_DATA_WORDS);
      end
      @(posedge CLK); #1;
    end
    RD_DATA_READY = 1'b1;
    #1;
    total++;
    if (WR_DATA_READY !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got %b exp 1", WR_DATA_READY);
    end
    send(8'h05, 1'b0);
    total++;
    if (RD_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL release_valid got %b exp 0", RD_DATA_VALID);
    end
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    total++;
    if (RD_DATA !== 32'h08070605) begin
      bad++;
      $display("FAIL after_stall_word got %h exp 08070605", RD_DATA);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    out_cyc.delete();
    RD_DATA_READY = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    total++;
    if (cyc - c0 !== 8) begin
      bad++;
      $display("FAIL b2b_input_cycles got %0d exp 8", cyc - c0);
    end
    drain();
    total++;
    if (out_cyc.size() !== 2) begin
      bad++;
      $display("FAIL b2b_output_count got %0d exp 2", out_cyc.size());
    end else begin
      total++;
      if (out_cyc[1] - out_cyc[0] !== 4) begin
        bad++;
        $display("FAIL b2b_spacing got %0d exp 4", out_cyc[1] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    RD_DATA_READY = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    WR_DATA_VALID = 1'b0;
    RST_IN = 1'b1;
    @(posedge CLK); #1;
    total++;
    if ({RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got valid=%b data=%h words=%0d end=%b exp all zero",
               RD_DATA_VALID, RD_DATA, RD_DATA_WORDS, RD_DATA_END);
    end
    RST_IN = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    send(8'h50, 1'b0);
    send(8'h60, 1'b0);
    total++;
    if (RD_DATA !== 32'h60504030 || RD_DATA_WORDS !== 3'd4) begin
      bad++;
      $display("FAIL post_reset_word got data=%h words=%0d exp data=60504030 words=4", RD_DATA, RD_DATA_WORDS);
    end
    drain();
    // A pending, unaccepted word must be dropped by reset.
    send(8'h71, 1'b1);
    RD_DATA_READY = 1'b0;
    WR_DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    RST_IN = 1'b1;
    @(posedge CLK); #1;
    RST_IN = 1'b0;
    exp_q.delete();
    total++;
    if (RD_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_pending got valid=%b exp 0", RD_DATA_VALID);
    end
    drain();
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 4) == 0));
    end
    rand_rdy = 1'b0;
    RD_DATA_READY = 1'b1;
    send(8'hEE, 1'b1);
    drain();
  endtask

  initial begin
    RST_IN = 1'b1;
    WR_DATA = '0;
    WR_DATA_VALID = 1'b0;
    WR_DATA_END = 1'b0;
    RD_DATA_READY = 1'b1;
    test_reset();
    test_stream();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
